// File: rtl/serial_port.sv
// rtl/serial_port.sv - memory-mapped 8N1 UART with TX FIFO, RX holding register and IRQ
//
// Ports:
//   clk_i    system clock, all state on the rising edge
//   reset_i  synchronous active-high reset
//   cs_i     chip select from the address decoder
//   rw_i     bus direction, 0 = read, 1 = write
//   addr_i   register offset
//   di_i     CPU write data
//   do_o     read data, combinational; 8'h00 unless a read is selected
//   rxd_i    asynchronous serial input, idle high
//   txd_o    serial output, idle high
//   irq_o    level interrupt, active-high
//
// Registers: 0 DATA, 1 STATUS, 2 DIV_LO, 3 DIV_HI, 4 CTRL; 5..F read as zero.
module serial_port #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd103
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       cs_i,
  input  logic       rw_i,
  input  logic [3:0] addr_i,
  input  logic [7:0] di_i,
  output logic [7:0] do_o,
  input  logic       rxd_i,
  output logic       txd_o,
  output logic       irq_o
);

  localparam int unsigned PW       = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = 1;
  localparam logic [PW:0]   CNT_ONE  = 1;
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  // Bus decode
  logic wr_en, rd_en;
  logic wr_data, wr_status, wr_div_lo, wr_div_hi, wr_ctrl, rd_data;
  assign wr_en     = cs_i & rw_i;
  assign rd_en     = cs_i & ~rw_i;
  assign wr_data   = wr_en & (addr_i == 4'h0);
  assign wr_status = wr_en & (addr_i == 4'h1);
  assign wr_div_lo = wr_en & (addr_i == 4'h2);
  assign wr_div_hi = wr_en & (addr_i == 4'h3);
  assign wr_ctrl   = wr_en & (addr_i == 4'h4);
  assign rd_data   = rd_en & (addr_i == 4'h0);

  // State
  logic [15:0]   div_q, div_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]   count_q, count_d;
  state_e        tx_state_q, tx_state_d;
  logic [15:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          sync1_q, sync2_q, sync3_q;
  state_e        rx_state_q, rx_state_d;
  logic [15:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_ovr_q, rx_ovr_d;
  logic          frm_err_q, frm_err_d;
  logic          tx_ovf_q, tx_ovf_d;

  // Divisors below 7 are clamped so a bit period is never shorter than 8 clocks.
  logic [15:0] div_eff, half_bit;
  assign div_eff  = (div_q < 16'd7) ? 16'd7 : div_q;
  assign half_bit = {1'b0, div_eff[15:1]} + {15'b0, div_eff[0]};  // (div_eff+1)/2

  logic fifo_empty, fifo_full, tx_idle, tx_pop, push_ok, tx_ovf_evt;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);
  assign tx_idle    = fifo_empty & (tx_state_q == S_IDLE);
  // A pop in the same cycle frees a slot, so a push onto a full FIFO still lands.
  assign push_ok    = wr_data & (~fifo_full | tx_pop);
  assign tx_ovf_evt = wr_data & fifo_full & ~tx_pop;

  always_comb begin
    div_d  = div_q;
    ctrl_d = ctrl_q;
    if (wr_div_lo) div_d[7:0]  = di_i;
    if (wr_div_hi) div_d[15:8] = di_i;
    if (wr_ctrl)   ctrl_d      = di_i[1:0];
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + PTR_ONE;
    if (tx_pop)  rptr_d = rptr_q + PTR_ONE;
    case ({push_ok, tx_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // TX FSM. Each state's counter is reloaded from div_eff when a bit period
  // begins, so divisor writes apply from the next bit onward.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = mem_q[rptr_q];
          tx_cnt_d   = div_eff;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d   = div_eff;
          tx_bit_d   = 3'd0;
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = div_eff;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == 16'd0) begin
          if (!fifo_empty) begin
            // Back-to-back frame: no idle gap after the stop bit.
            tx_pop     = 1'b1;
            tx_sh_d    = mem_q[rptr_q];
            tx_cnt_d   = div_eff;
            tx_state_d = S_START;
          end else begin
            tx_state_d = S_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (tx_state_q)
      S_START: txd_o = 1'b0;
      S_DATA:  txd_o = tx_sh_q[0];
      default: txd_o = 1'b1;
    endcase
  end

  // RX FSM on the synchronized line (sync2_q); sync3_q is its previous value
  // for falling-edge detection.
  logic rx_done, frm_evt;
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_done    = 1'b0;
    frm_evt    = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (!sync2_q && sync3_q) begin
          rx_cnt_d   = half_bit - 16'd1;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_q == 16'd0) begin
          if (!sync2_q) begin
            rx_cnt_d   = div_eff;
            rx_bit_d   = 3'd0;
            rx_state_d = S_DATA;
          end else begin
            rx_state_d = S_IDLE;  // glitch, not a start bit
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == 16'd0) begin
          rx_sh_d  = {sync2_q, rx_sh_q[7:1]};
          rx_cnt_d = div_eff;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == 16'd0) begin
          rx_done    = sync2_q;
          frm_evt    = ~sync2_q;
          rx_state_d = S_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // Holding register and sticky flags. A DATA read frees the holding register
  // before a byte completing in the same cycle is considered, and W1C clears
  // apply before same-cycle events so the event wins.
  always_comb begin
    logic valid_after_rd;
    valid_after_rd = rx_valid_q & ~rd_data;
    rx_valid_d     = valid_after_rd;
    rx_data_d      = rx_data_q;
    rx_ovr_d       = rx_ovr_q  & ~(wr_status & di_i[3]);
    frm_err_d      = frm_err_q & ~(wr_status & di_i[4]);
    tx_ovf_d       = tx_ovf_q  & ~(wr_status & di_i[5]);
    if (rx_done) begin
      if (!valid_after_rd) begin
        rx_data_d  = rx_sh_q;
        rx_valid_d = 1'b1;
      end else begin
        rx_ovr_d = 1'b1;
      end
    end
    if (frm_evt)    frm_err_d = 1'b1;
    if (tx_ovf_evt) tx_ovf_d  = 1'b1;
  end

  logic [7:0] status;
  assign status = {2'b00, tx_ovf_q, frm_err_q, rx_ovr_q, rx_valid_q, tx_idle, fifo_full};
  assign irq_o  = (ctrl_q[0] & rx_valid_q) | (ctrl_q[1] & tx_idle);

  always_comb begin
    do_o = 8'h00;
    if (rd_en) begin
      case (addr_i)
        4'h0:    do_o = rx_data_q;
        4'h1:    do_o = status;
        4'h2:    do_o = div_q[7:0];
        4'h3:    do_o = div_q[15:8];
        4'h4:    do_o = {6'b0, ctrl_q};
        default: do_o = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= di_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_q      <= DIV_RESET;
      ctrl_q     <= 2'b00;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_bit_q   <= 3'd0;
      tx_sh_q    <= 8'h00;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      sync3_q    <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      frm_err_q  <= 1'b0;
      tx_ovf_q   <= 1'b0;
    end else begin
      div_q      <= div_d;
      ctrl_q     <= ctrl_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      sync1_q    <= rxd_i;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      frm_err_q  <= frm_err_d;
      tx_ovf_q   <= tx_ovf_d;
    end
  end

endmodule

// File: tb/tb_serial_port.sv
// tb/tb_serial_port.sv - self-checking bench for serial_port against a frame-level model
module tb_serial_port;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset, cs, rw, rxd;
  logic [3:0] addr;
  logic [7:0] di, dout;
  logic       txd, irq;

  always #5 clk = ~clk;

  serial_port #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd103)) dut (
    .clk_i(clk), .reset_i(reset), .cs_i(cs), .rw_i(rw), .addr_i(addr),
    .di_i(di), .do_o(dout), .rxd_i(rxd), .txd_o(txd), .irq_o(irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: TX as a queue of bytes plus the frame currently on the wire,
  // RX as a delay line plus a list of sample points relative to the start edge.
  logic [7:0]  m_txq[$];
  bit          m_tx_active;
  logic [9:0]  m_frame;
  int          m_tx_bit, m_tx_rem;
  logic [15:0] m_div;
  logic [1:0]  m_ctrl;
  bit          m_ovf, m_frm, m_ovr, m_valid;
  logic [7:0]  m_rxdata;
  logic        m_dly[3];
  int          m_rx_pos;   // -2 idle, -1 start check, 0..7 data bit, 8 stop
  int          m_rx_wait;
  logic [7:0]  m_rx_byte;
  bit          rx_line[$];

  function automatic int deff();
    return (m_div < 16'd7) ? 7 : int'(m_div);
  endfunction

  function automatic bit m_tx_idle();
    return (m_txq.size() == 0) && !m_tx_active;
  endfunction

  function automatic logic [7:0] m_status();
    return {2'b00, m_ovf, m_frm, m_ovr, m_valid, m_tx_idle(), m_txq.size() == DEPTH};
  endfunction

  function automatic logic [7:0] m_do();
    if (!(cs && !rw)) return 8'h00;
    case (addr)
      4'h0: return m_rxdata;
      4'h1: return m_status();
      4'h2: return m_div[7:0];
      4'h3: return m_div[15:8];
      4'h4: return {6'b0, m_ctrl};
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic m_txd();
    return m_tx_active ? m_frame[m_tx_bit] : 1'b1;
  endfunction

  function automatic logic m_irq();
    return (m_ctrl[0] & m_valid) | (m_ctrl[1] & m_tx_idle());
  endfunction

  task automatic model_reset();
    m_txq.delete();
    m_tx_active = 0; m_tx_bit = 0; m_tx_rem = 0; m_frame = '1;
    m_div = 16'd103; m_ctrl = 2'b00;
    m_ovf = 0; m_frm = 0; m_ovr = 0; m_valid = 0; m_rxdata = 8'h00;
    for (int k = 0; k < 3; k++) m_dly[k] = 1'b1;
    m_rx_pos = -2; m_rx_wait = 0; m_rx_byte = 8'h00;
  endtask

  task automatic model_step();
    int d;
    logic line, prev;
    bit done, frm_e, ovf_e, wr, rd;
    if (reset) begin
      model_reset();
      return;
    end
    d = deff();
    done = 0; frm_e = 0; ovf_e = 0;
    // TX wire
    if (m_tx_active) begin
      m_tx_rem--;
      if (m_tx_rem == 0) begin
        m_tx_bit++;
        if (m_tx_bit == 10) m_tx_active = 0;
        else m_tx_rem = d + 1;
      end
    end
    if (!m_tx_active && m_txq.size() > 0) begin
      m_frame = {1'b1, m_txq.pop_front(), 1'b0};
      m_tx_active = 1; m_tx_bit = 0; m_tx_rem = d + 1;
    end
    // RX: line seen two clocks late
    line = m_dly[1];
    prev = m_dly[2];
    if (m_rx_pos == -2) begin
      if (!line && prev) begin
        m_rx_pos = -1;
        m_rx_wait = (d + 1) / 2;
      end
    end else begin
      m_rx_wait--;
      if (m_rx_wait == 0) begin
        if (m_rx_pos == -1) begin
          if (line) m_rx_pos = -2;
          else begin m_rx_pos = 0; m_rx_wait = d + 1; end
        end else if (m_rx_pos < 8) begin
          m_rx_byte[m_rx_pos] = line;
          m_rx_pos++;
          m_rx_wait = d + 1;
        end else begin
          if (line) done = 1; else frm_e = 1;
          m_rx_pos = -2;
        end
      end
    end
    m_dly[2] = m_dly[1]; m_dly[1] = m_dly[0]; m_dly[0] = rxd;
    // Bus
    wr = cs && rw;
    rd = cs && !rw;
    if (wr && addr == 4'h0) begin
      if (m_txq.size() < DEPTH) m_txq.push_back(di);
      else ovf_e = 1;
    end
    if (wr && addr == 4'h1) begin
      if (di[5]) m_ovf = 0;
      if (di[4]) m_frm = 0;
      if (di[3]) m_ovr = 0;
    end
    if (wr && addr == 4'h2) m_div[7:0]  = di;
    if (wr && addr == 4'h3) m_div[15:8] = di;
    if (wr && addr == 4'h4) m_ctrl      = di[1:0];
    if (rd && addr == 4'h0) m_valid = 0;
    if (done) begin
      if (!m_valid) begin m_rxdata = m_rx_byte; m_valid = 1; end
      else m_ovr = 1;
    end
    if (frm_e) m_frm = 1;
    if (ovf_e) m_ovf = 1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // One bus cycle: drive, check do_o, clock, advance the model, check txd/irq.
  task automatic cycle(input bit rst, input bit c, input bit w, input logic [3:0] a,
                       input logic [7:0] d, output logic [7:0] rdv);
    reset = rst; cs = c; rw = w; addr = a; di = d;
    rxd = (rx_line.size() > 0) ? rx_line.pop_front() : 1'b1;
    #1;
    rdv = dout;
    if (!rst) chk("do", dout, m_do());
    @(posedge clk);
    model_step();
    #1;
    chk("txd", txd, m_txd());
    chk("irq", irq, m_irq());
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    logic [7:0] v;
    cycle(0, 1, 1, a, d, v);
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] v);
    cycle(0, 1, 0, a, 8'h00, v);
  endtask

  task automatic idle(input int n);
    logic [7:0] v;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 4'h0, 8'h00, v);
  endtask

  task automatic push_frame(input logic [7:0] b, input bit stop, input int p);
    for (int i = 0; i < p; i++) rx_line.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < p; i++) rx_line.push_back(b[k]);
    for (int i = 0; i < p; i++) rx_line.push_back(stop);
    rx_line.push_back(1'b1);
  endtask

  initial begin
    logic [7:0] v;
    logic [9:0] frame10;
    logic       trace[88];
    int         errs, r;

    model_reset();
    cycle(1, 0, 0, 4'h0, 8'h00, v);
    cycle(1, 0, 0, 4'h0, 8'h00, v);

    // Reset state
    rd(4'h1, v); chk("reset_status", v, 8'h02);
    rd(4'h2, v); chk("reset_div_lo", v, 8'h67);
    rd(4'h3, v); chk("reset_div_hi", v, 8'h00);
    chk("reset_txd", txd, 1'b1);
    chk("reset_irq", irq, 1'b0);

    // Single frame 8'hA5 at DIV=7
    wr(4'h2, 8'h07);
    wr(4'h3, 8'h00);
    wr(4'h0, 8'hA5);
    for (int i = 0; i < 88; i++) begin
      idle(1);
      trace[i] = txd;
    end
    frame10 = 10'b1101001010;
    errs = 0;
    for (int i = 0; i < 88; i++)
      if (trace[i] !== ((i < 80) ? frame10[i / 8] : 1'b1)) errs++;
    chk("a5_trace_bad_bits", errs, 0);
    for (int k = 0; k < 10; k++) chk($sformatf("a5_bit%0d", k), trace[k * 8 + 4], frame10[k]);
    rd(4'h1, v); chk("a5_tx_idle", v, 8'h02);

    // FIFO fill and overflow
    for (int i = 0; i < 5; i++) wr(4'h0, 8'h10 + 8'(i));
    rd(4'h1, v); chk("fifo_full_no_ovf", v, 8'h01);
    wr(4'h0, 8'hEE);
    rd(4'h1, v); chk("fifo_ovf", v, 8'h21);
    wr(4'h1, 8'h20);
    idle(420);
    rd(4'h1, v); chk("fifo_drained", v, 8'h02);

    // RX single byte, then overrun
    push_frame(8'h3C, 1'b1, 8);
    idle(100);
    rd(4'h1, v); chk("rx_valid", v, 8'h06);
    rd(4'h0, v); chk("rx_data_3c", v, 8'h3C);
    rd(4'h1, v); chk("rx_valid_clr", v, 8'h02);
    push_frame(8'h11, 1'b1, 8);
    push_frame(8'h22, 1'b1, 8);
    idle(190);
    rd(4'h1, v); chk("rx_ovr", v, 8'h0E);
    rd(4'h0, v); chk("rx_ovr_keeps_first", v, 8'h11);

    // Glitch reject and framing error
    wr(4'h1, 8'h38);
    rx_line.push_back(1'b0); rx_line.push_back(1'b0);
    idle(40);
    rd(4'h1, v); chk("glitch_rejected", v, 8'h02);
    push_frame(8'h55, 1'b0, 8);
    idle(100);
    rd(4'h1, v); chk("frm_err", v, 8'h12);
    wr(4'h1, 8'h38);
    rd(4'h1, v); chk("w1c_clear", v, 8'h02);

    // Interrupts and reset mid-frame
    wr(4'h4, 8'h01);
    push_frame(8'h5A, 1'b1, 8);
    idle(100);
    chk("irq_rx", irq, 1'b1);
    rd(4'h0, v);
    chk("irq_rx_cleared", irq, 1'b0);
    wr(4'h4, 8'h02);
    chk("irq_tx_idle", irq, 1'b1);
    wr(4'h0, 8'h81);
    idle(20);
    chk("irq_tx_busy", irq, 1'b0);
    cycle(1, 0, 0, 4'h0, 8'h00, v);
    chk("reset_mid_tx_txd", txd, 1'b1);
    chk("reset_mid_tx_irq", irq, 1'b0);
    wr(4'h2, 8'h07);

    // Randomized traffic
    for (int n = 0; n < 8000; n++) begin
      if (rx_line.size() == 0 && $urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 4) == 0) begin
          for (int i = 0; i < int'($urandom_range(1, 3)); i++) rx_line.push_back(1'b0);
          rx_line.push_back(1'b1);
        end else begin
          push_frame(8'($urandom), $urandom_range(0, 7) != 0, deff());
        end
        for (int i = 0; i < int'($urandom_range(0, 6)); i++) rx_line.push_back(1'b1);
      end
      r = $urandom_range(0, 999);
      if (r < 1)        cycle(1, 0, 0, 4'h0, 8'h00, v);
      else if (r < 700) idle(1);
      else if (r < 780) wr(4'h0, 8'($urandom));
      else if (r < 840) rd(4'h0, v);
      else if (r < 880) rd(4'h1, v);
      else if (r < 910) wr(4'h1, 8'($urandom));
      else if (r < 930) wr(4'h4, 8'($urandom));
      else if (r < 950) wr(4'h2, 8'($urandom_range(0, 12)));
      else if (r < 955) wr(4'h3, 8'h00);
      else if (r < 980) rd(4'($urandom), v);
      else              wr(4'($urandom_range(5, 15)), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
